// File: rtl/frog_referee_if.sv
// Signal bundle between the frog/car game logic (master) and frog_referee (slave).
interface frog_referee_if #(
  parameter int NUM_LANES = 4
);
  logic [5*NUM_LANES-1:0] i_car_x;
  logic [4:0]             i_frog_x;
  logic [3:0]             i_frog_y;
  logic                   i_start;
  logic [6:0]             o_level;
  logic [1:0]             o_lives;
  logic                   o_hit;
  logic                   o_respawn;
  logic                   o_game_over;

  modport master (
    output i_car_x, i_frog_x, i_frog_y, i_start,
    input  o_level, o_lives, o_hit, o_respawn, o_game_over
  );

  modport slave (
    input  i_car_x, i_frog_x, i_frog_y, i_start,
    output o_level, o_lives, o_hit, o_respawn, o_game_over
  );
endinterface

// File: rtl/frog_referee.sv
// Frog game referee: collision/goal detection, lives, level and game-over ownership.
// Optional build macro FROG_REFEREE_INVINCIBLE_EN: hits still freeze/respawn but never cost a life.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_PLAY  | detection active; collisions cost a life, goals bump level
// S_HIT   | post-hit freeze, counter runs down to 0 then respawn
// S_OVER  | lives exhausted; everything frozen until i_start
module frog_referee #(
  parameter int          NUM_LANES      = 4,
  parameter int          GRID_W         = 20,
  parameter int          LIVES_INIT     = 3,
  parameter logic [24:0] RESPAWN_CYCLES = 25'd1000
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  frog_referee_if.slave  bus
);

  localparam logic [3:0] GOAL_ROW  = 4'(NUM_LANES + 1);
  localparam logic [5:0] X_LIMIT   = 6'(GRID_W);
  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
  localparam logic [6:0] LEVEL_RST = 7'd1;
  localparam logic [6:0] LEVEL_MAX = 7'd127;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HIT  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [6:0]  level_q, level_n;
  logic [1:0]  lives_q, lives_n;
  logic [24:0] cnt_q,   cnt_n;
  logic        hit_q,   hit_n;
  logic        resp_q,  resp_n;

  logic [4:0]  lane_x;
  logic        lane_sel;
  logic        collide;
  logic        goal;

  // Pick the car sharing the frog's row; rows outside the lane band select nothing.
  always_comb begin
    lane_x   = 5'd0;
    lane_sel = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.i_frog_y == 4'(k + 1)) begin
        lane_x   = bus.i_car_x[5*k +: 5];
        lane_sel = 1'b1;
      end
    end
  end

  assign collide = (state_q == S_PLAY) && lane_sel &&
                   ({1'b0, lane_x} < X_LIMIT) && (lane_x == bus.i_frog_x);
  assign goal    = (state_q == S_PLAY) && (bus.i_frog_y == GOAL_ROW);

  always_comb begin
    state_n = state_q;
    level_n = level_q;
    lives_n = lives_q;
    cnt_n   = cnt_q;
    hit_n   = 1'b0;
    resp_n  = 1'b0;

    case (state_q)
      S_PLAY: begin
        if (collide) begin
          hit_n = 1'b1;
`ifdef FROG_REFEREE_INVINCIBLE_EN
          state_n = S_HIT;
          cnt_n   = RESPAWN_CYCLES - 25'd1;
`else
          if (lives_q <= 2'd1) begin
            lives_n = 2'd0;
            state_n = S_OVER;
          end else begin
            lives_n = lives_q - 2'd1;
            state_n = S_HIT;
            cnt_n   = RESPAWN_CYCLES - 25'd1;
          end
`endif
        end else if (goal) begin
          level_n = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 7'd1;
          resp_n  = 1'b1;
        end
      end

      S_HIT: begin
        if (cnt_q == 25'd0) begin
          state_n = S_PLAY;
          resp_n  = 1'b1;
        end else begin
          cnt_n = cnt_q - 25'd1;
        end
      end

      S_OVER: begin
        if (bus.i_start) begin
          state_n = S_PLAY;
          lives_n = LIVES_RST;
          level_n = LEVEL_RST;
          resp_n  = 1'b1;
        end
      end

      default: begin
        state_n = S_PLAY;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_PLAY;
      level_q <= LEVEL_RST;
      lives_q <= LIVES_RST;
      cnt_q   <= 25'd0;
      hit_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      level_q <= level_n;
      lives_q <= lives_n;
      cnt_q   <= cnt_n;
      hit_q   <= hit_n;
      resp_q  <= resp_n;
    end
  end

  assign bus.o_level     = level_q;
  assign bus.o_lives     = lives_q;
  assign bus.o_hit       = hit_q;
  assign bus.o_respawn   = resp_q;
  assign bus.o_game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_frog_referee.sv
// Scoreboard bench for frog_referee: expected output snapshots are queued per driven cycle.
module tb_frog_referee;
  localparam int NL   = 4;
  localparam int RESP = 1000;
`ifdef FROG_REFEREE_INVINCIBLE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  typedef struct packed {
    logic       hit;
    logic       respawn;
    logic       game_over;
    logic [1:0] lives;
    logic [6:0] level;
  } snap_t;

  logic i_Clk   = 1'b0;
  logic i_Reset = 1'b1;

  frog_referee_if #(.NUM_LANES(NL)) bus();
  frog_referee #(.NUM_LANES(NL)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic [19:0] idle_cars;

  function automatic snap_t mk(input logic h, input logic r, input logic g,
                               input logic [1:0] l, input logic [6:0] v);
    return {h, r, g, l, v};
  endfunction

  function automatic snap_t seen();
    return {bus.o_hit, bus.o_respawn, bus.o_game_over, bus.o_lives, bus.o_level};
  endfunction

  function automatic logic [19:0] cars(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  task automatic drive(input logic [19:0] cx, input logic [4:0] fx,
                       input logic [3:0] fy, input logic st);
    bus.i_car_x  = cx;
    bus.i_frog_x = fx;
    bus.i_frog_y = fy;
    bus.i_start  = st;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic push_drive(input snap_t e, input string tag, input logic [19:0] cx,
                            input logic [4:0] fx, input logic [3:0] fy, input logic st);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    drive(cx, fx, fy, st);
  endtask

  task automatic do_reset();
    bus.i_car_x  = idle_cars;
    bus.i_frog_x = 5'd0;
    bus.i_frog_y = 4'd0;
    bus.i_start  = 1'b0;
    i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got, e;
    string t;
    do_reset();
    drive(cars(31, 31, 31, 31), 5'd3, 4'd0, 1'b0);
    #3;
    i_Reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 2'd3, 7'd1));
    tag_q.push_back("reset_async");
    #1;
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "reset_release", idle_cars, 5'd0, 4'd0, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
  endtask

  task automatic test_hit();
    snap_t got, e;
    string t;
    logic [1:0] lv1, lv2;
    lv1 = INV ? 2'd3 : 2'd2;
    lv2 = INV ? 2'd3 : 2'd1;
    do_reset();
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "near_miss", cars(31, 8, 31, 31), 5'd7, 4'd2, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(1, 0, 0, lv1, 7'd1), "hit_pulse", cars(31, 7, 31, 31), 5'd7, 4'd2, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    // Frog stays parked on the car for the whole freeze: no second hit allowed.
    for (int k = 1; k <= RESP; k++) begin
      push_drive((k == RESP) ? mk(0, 1, 0, lv1, 7'd1) : mk(0, 0, 0, lv1, 7'd1),
                 (k == RESP) ? "hit_respawn" : "hit_freeze",
                 cars(31, 7, 31, 31), 5'd7, 4'd2, 1'b0);
      got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL %s(cycle %0d): got %b expected %b", t, k, got, e);
      else n_pass++;
    end
    push_drive(mk(1, 0, 0, lv2, 7'd1), "hit_after_resume", cars(31, 7, 31, 31), 5'd7, 4'd2, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
  endtask

  task automatic test_game_over();
    snap_t got, e;
    string t;
    logic [1:0] lv;
    logic go;
    do_reset();
    for (int h = 0; h < 3; h++) begin
      lv = INV ? 2'd3 : 2'(2 - h);
      go = !INV && (h == 2);
      push_drive(mk(1, 0, go, lv, 7'd1), "over_hit", cars(12, 31, 31, 31), 5'd12, 4'd1, 1'b0);
      got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL %s(%0d): got %b expected %b", t, h, got, e); else n_pass++;
      if (!go) begin
        for (int k = 1; k < RESP; k++) drive(idle_cars, 5'd0, 4'd0, 1'b0);
        push_drive(mk(0, 1, 0, lv, 7'd1), "over_hit_respawn", idle_cars, 5'd0, 4'd0, 1'b0);
        got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
        if (got !== e) $display("FAIL %s(%0d): got %b expected %b", t, h, got, e); else n_pass++;
      end
    end
    push_drive(INV ? mk(0, 1, 0, 2'd3, 7'd2) : mk(0, 0, 1, 2'd0, 7'd1), "over_frozen",
               cars(12, 31, 31, 31), 5'd12, 4'd5, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(INV ? mk(0, 0, 0, 2'd3, 7'd2) : mk(0, 1, 0, 2'd3, 7'd1), "restart",
               idle_cars, 5'd0, 4'd0, 1'b1);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(INV ? mk(0, 0, 0, 2'd3, 7'd2) : mk(0, 0, 0, 2'd3, 7'd1), "after_restart",
               idle_cars, 5'd0, 4'd0, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
  endtask

  task automatic test_goal();
    snap_t got, e;
    string t;
    int lvl;
    do_reset();
    push_drive(mk(0, 1, 0, 2'd3, 7'd2), "goal_once", idle_cars, 5'd4, 4'd5, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(0, 0, 0, 2'd3, 7'd2), "goal_leave", idle_cars, 5'd4, 4'd0, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    for (int j = 1; j <= 130; j++) begin
      lvl = (2 + j > 127) ? 127 : 2 + j;
      push_drive(mk(0, 1, 0, 2'd3, 7'(lvl)), "goal_hold", idle_cars, 5'd4, 4'd5, 1'b0);
      got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL %s(%0d): got %b expected %b", t, j, got, e); else n_pass++;
    end
    push_drive(mk(0, 0, 0, 2'd3, 7'd127), "goal_saturated", idle_cars, 5'd4, 4'd0, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
  endtask

  task automatic test_no_hit();
    snap_t got, e;
    string t;
    do_reset();
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "invalid_x25", cars(31, 31, 25, 31), 5'd25, 4'd3, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "invalid_x20", cars(31, 31, 20, 31), 5'd20, 4'd3, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "start_row0", cars(5, 5, 5, 5), 5'd5, 4'd0, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(0, 0, 0, 2'd3, 7'd1), "row_above_goal", cars(5, 5, 5, 5), 5'd5, 4'd6, 1'b1);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    push_drive(mk(1, 0, 0, INV ? 2'd3 : 2'd2, 7'd1), "edge_x19", cars(31, 31, 19, 31),
               5'd19, 4'd3, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    do_reset();
    push_drive(mk(1, 0, 0, INV ? 2'd3 : 2'd2, 7'd1), "top_lane_x0", cars(31, 31, 31, 0),
               5'd0, 4'd4, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
  endtask

  task automatic test_reset_mid_hit();
    snap_t got, e;
    string t;
    do_reset();
    push_drive(mk(1, 0, 0, INV ? 2'd3 : 2'd2, 7'd1), "mid_hit_entry", cars(31, 7, 31, 31),
               5'd7, 4'd2, 1'b0);
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    for (int k = 0; k < 499; k++) drive(idle_cars, 5'd0, 4'd0, 1'b0);
    #3;
    i_Reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 2'd3, 7'd1));
    tag_q.push_back("mid_hit_reset");
    #1;
    got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL %s: got %b expected %b", t, got, e); else n_pass++;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      push_drive(mk(0, 0, 0, 2'd3, 7'd1), "quiet_after_reset", idle_cars, 5'd0, 4'd0, 1'b0);
      got = seen(); e = exp_q.pop_front(); t = tag_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL %s(cycle %0d): got %b expected %b", t, k, got, e);
      else n_pass++;
    end
  endtask

  initial begin
    idle_cars    = cars(31, 31, 31, 31);
    bus.i_car_x  = idle_cars;
    bus.i_frog_x = 5'd0;
    bus.i_frog_y = 4'd0;
    bus.i_start  = 1'b0;
    test_reset();
    test_hit();
    test_game_over();
    test_goal();
    test_no_hit();
    test_reset_mid_hit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/frog_referee.md
# frog_referee

Game referee sitting between the car lanes and the frog/player logic. Each cycle it compares the frog position against the current x position of every lane's car, detects collisions and goal arrivals, and owns the lives counter, game-over flag and the 7-bit level value that feeds back to every car instance. It is the consumer of car positions and the producer of `level`.

## Interface
- `NUM_LANES`, 4: car lanes on rows 1..NUM_LANES; row 0 is start, row NUM_LANES+1 is goal.
- `GRID_W`, 20: columns 0..GRID_W-1; car x values ≥ GRID_W are invalid and never collide.
- `LIVES_INIT`, 3: lives loaded at reset and restart (1..3).
- `RESPAWN_CYCLES`, 25'd1000: length of the post-hit freeze, ≥ 1.

Ports:
- `i_Clk` in 1: system clock.
- `i_Reset` in 1: asynchronous, active-high reset.
- `i_car_x` in 5*NUM_LANES: packed car x positions; lane k (row k+1) at bits [5k+4:5k].
- `i_frog_x` in 5: frog column.
- `i_frog_y` in 4: frog row.
- `i_start` in 1: restart request, honoured only in OVER.
- `o_level` out 7: current level, drives car `level` inputs.
- `o_lives` out 2: remaining lives.
- `o_hit` out 1: one-cycle pulse on collision.
- `o_respawn` out 1: one-cycle pulse telling frog logic to return to row 0.
- `o_game_over` out 1: high while in OVER.

## Operation
- States: PLAY, HIT, OVER. Reset → PLAY, `o_level`=1, `o_lives`=LIVES_INIT, `o_hit`=0, `o_respawn`=0, `o_game_over`=0, respawn counter 0.
- Collision condition: state PLAY, 1 ≤ `i_frog_y` ≤ NUM_LANES, lane x = `i_car_x`[lane i_frog_y-1] < GRID_W, and lane x == `i_frog_x`.
- Goal condition: state PLAY and `i_frog_y` == NUM_LANES+1.
- PLAY + collision: `o_hit` pulses; lives decrement. If lives was 1 → lives 0, go to OVER (no respawn pulse). Else → HIT, counter loaded with RESPAWN_CYCLES-1.
- PLAY + goal: `o_level` increments, saturating at 127; `o_respawn` pulses; stay in PLAY. Collision has priority if both true (cannot occur with legal rows; defined anyway).
- HIT: collisions and goals ignored; counter decrements each cycle; on counter == 0 → PLAY with `o_respawn` pulse.
- OVER: `o_game_over`=1, all detection ignored, level and lives frozen. `i_start`=1 → PLAY, lives=LIVES_INIT, level=1, `o_respawn` pulse, `o_game_over`=0 next cycle.
- `i_start` outside OVER has no effect. Frog rows > NUM_LANES+1 are ignored.
- Asserting `i_Reset` at any time, including mid-HIT, immediately forces reset values; no pulse is emitted on release.

## Timing
- All outputs registered. Condition true at rising edge N → `o_hit`/`o_respawn`/`o_lives`/`o_level`/state update visible after edge N; pulses are exactly one cycle wide.
- HIT lasts exactly RESPAWN_CYCLES cycles; first PLAY cycle coincides with the `o_respawn` pulse; detection resumes on the following edge.
- A frog remaining on a goal row increments level once per cycle; the frog logic must consume `o_respawn` within one cycle.
- `o_game_over` rises on the same edge that drives `o_lives` to 0.

## Configuration
- `FROG_REFEREE_INVINCIBLE_EN`: when defined, collisions still pulse `o_hit` and enter HIT/respawn, but lives never decrement and OVER is unreachable. When undefined, behaviour is as described above.

## Test plan
- Reset with lives=3: frog (7,2), lane 1 car x=7 → `o_hit` one cycle, `o_lives`=2, HIT for 1000 cycles, then `o_respawn` pulse.
- Frog (7,2), lane 1 car x=8, then car x=7 while in HIT → no second hit; `o_lives` unchanged.
- Three successive hits from LIVES_INIT=3 → `o_lives`=0, `o_game_over`=1, no `o_respawn`; `i_start` pulse → lives 3, level 1, `o_respawn` pulse.
- Frog at row 5 (NUM_LANES=4) one cycle → `o_level` 1→2, `o_respawn` pulse; hold level at 127 and repeat → stays 127.
- Car x=25 with frog x=25 on that lane → no hit; frog row 0 with car x matching → no hit.
- Assert `i_Reset` mid-HIT (counter=500) → immediate PLAY, lives=3, level=1; with `FROG_REFEREE_INVINCIBLE_EN` three hits leave `o_lives`=3, `o_game_over`=0.
